// File: rtl/free_list_pkg.sv
// Shared constants and types for the physical-register free list.
package free_list_pkg;

  localparam int unsigned PR      = 6;
  localparam int unsigned AR_NUM  = 32;
  localparam int unsigned FL_SIZE = 2**PR - AR_NUM;
  localparam int unsigned PTR_W   = $clog2(FL_SIZE);

  typedef logic [PTR_W-1:0] FL_PTR;
  typedef logic [PR-1:0]    PR_TAG;

  // Tag held by free-list slot idx out of reset: first tag past the architectural map.
  function automatic PR_TAG reset_tag(input int unsigned idx);
    return PR_TAG'(AR_NUM + idx);
  endfunction

endpackage

// File: rtl/fl_compact3.sv
// Popcount and prefix offsets for three enables, compacted from way 2 down to way 0.
module fl_compact3 (
  input  logic [2:0] i_en,
  output logic [1:0] o_off2,
  output logic [1:0] o_off1,
  output logic [1:0] o_off0,
  output logic [1:0] o_total
);

  always_comb begin
    o_off2  = 2'd0;
    o_off1  = {1'b0, i_en[2]};
    o_off0  = {1'b0, i_en[2]} + {1'b0, i_en[1]};
    o_total = o_off0 + {1'b0, i_en[0]};
  end

endmodule

// File: rtl/free_list.sv
// Circular FIFO of free physical tags: up to 3 allocations and 3 frees per cycle,
// with squash rollback of the head to the architectural head.
module free_list
  import free_list_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        i_dis_new_pr_en,
  output logic [2:0]        o_free_pr_valid,
  output logic [3*PR-1:0]   o_free_pr,
  input  logic [2:0]        i_retire_en,
  input  logic [3*PR-1:0]   i_retire_told,
  input  logic              i_squash,
  output logic [PTR_W:0]    o_fl_count
);

  localparam int unsigned CW = PTR_W + 1;

  PR_TAG          r_entries [FL_SIZE];
  FL_PTR          r_head;
  FL_PTR          r_tail;
  FL_PTR          r_arch_head;
  logic [CW-1:0]  r_count;

  logic [1:0]     w_alloc_off2, w_alloc_off1, w_alloc_off0, w_alloc_req;
  logic [1:0]     w_ret_off2, w_ret_off1, w_ret_off0, w_ret_total;
  logic [1:0]     w_alloc;
  logic [CW-1:0]  w_alloc_req_ext;
  logic [CW:0]    w_count_sum;
  FL_PTR          w_rd_idx1, w_rd_idx0;
  FL_PTR          w_wr_idx2, w_wr_idx1, w_wr_idx0;
  FL_PTR          w_head_d, w_tail_d, w_arch_head_d;
  logic [CW-1:0]  w_count_d;

  fl_compact3 u_alloc_compact (
    .i_en    (i_dis_new_pr_en),
    .o_off2  (w_alloc_off2),
    .o_off1  (w_alloc_off1),
    .o_off0  (w_alloc_off0),
    .o_total (w_alloc_req)
  );

  fl_compact3 u_retire_compact (
    .i_en    (i_retire_en),
    .o_off2  (w_ret_off2),
    .o_off1  (w_ret_off1),
    .o_off0  (w_ret_off0),
    .o_total (w_ret_total)
  );

  // Over-request is clamped to what is actually free; when empty this yields zero.
  always_comb begin
    w_alloc_req_ext = CW'(w_alloc_req);
    w_alloc         = w_alloc_req;
    if (w_alloc_req_ext > r_count) begin
      w_alloc = r_count[1:0];
    end
  end

  always_comb begin
    w_rd_idx1 = r_head + FL_PTR'(w_alloc_off1);
    w_rd_idx0 = r_head + FL_PTR'(w_alloc_off0);
    w_wr_idx2 = r_tail + FL_PTR'(w_ret_off2);
    w_wr_idx1 = r_tail + FL_PTR'(w_ret_off1);
    w_wr_idx0 = r_tail + FL_PTR'(w_ret_off0);
  end

  always_comb begin
    o_free_pr[3*PR-1 -: PR] = r_entries[r_head];
    o_free_pr[2*PR-1 -: PR] = r_entries[w_rd_idx1];
    o_free_pr[PR-1   -: PR] = r_entries[w_rd_idx0];
  end

  // Availability is a function of count alone so dispatch can stall without a loop.
  always_comb begin
    if (r_count >= CW'(3)) begin
      o_free_pr_valid = 3'b111;
    end else if (r_count == CW'(2)) begin
      o_free_pr_valid = 3'b110;
    end else if (r_count == CW'(1)) begin
      o_free_pr_valid = 3'b100;
    end else begin
      o_free_pr_valid = 3'b000;
    end
  end

  assign o_fl_count = r_count;

  // Freed tags land at the tail and are only visible to allocation next cycle.
  always_comb begin
    w_tail_d      = r_tail + FL_PTR'(w_ret_total);
    w_arch_head_d = r_arch_head + FL_PTR'(w_ret_total);
    w_count_sum   = {1'b0, r_count} - (CW+1)'(w_alloc) + (CW+1)'(w_ret_total);
    if (i_squash) begin
      w_head_d  = w_arch_head_d;
      w_count_d = CW'(FL_SIZE);
    end else begin
      w_head_d  = r_head + FL_PTR'(w_alloc);
      w_count_d = w_count_sum[CW-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < FL_SIZE; i++) begin
        r_entries[i] <= reset_tag(i);
      end
    end else begin
      if (i_retire_en[2]) r_entries[w_wr_idx2] <= i_retire_told[3*PR-1 -: PR];
      if (i_retire_en[1]) r_entries[w_wr_idx1] <= i_retire_told[2*PR-1 -: PR];
      if (i_retire_en[0]) r_entries[w_wr_idx0] <= i_retire_told[PR-1   -: PR];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_arch_head <= '0;
      r_count     <= CW'(FL_SIZE);
    end else begin
      r_head      <= w_head_d;
      r_tail      <= w_tail_d;
      r_arch_head <= w_arch_head_d;
      r_count     <= w_count_d;
    end
  end

`ifndef SYNTHESIS
  // Empty is a defined state in which enables are simply dropped, so it is exempt.
  always @(posedge clock) begin
    if (!reset && !i_squash && r_count != '0) begin
      assert (w_alloc_req_ext <= r_count)
        else $error("free_list: dispatch asked for %0d tags with %0d free", w_alloc_req, r_count);
    end
    if (!reset && !i_squash) begin
      assert (w_count_sum <= (CW+1)'(FL_SIZE))
        else $error("free_list: free count would reach %0d", w_count_sum);
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// Random and directed bench for free_list against a queue-based free/in-flight tag model.
module tb_free_list;
  import free_list_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  logic [2:0]      dis_en;
  logic [2:0]      free_pr_valid;
  logic [3*PR-1:0] free_pr;
  logic [2:0]      retire_en;
  logic [3*PR-1:0] retire_told;
  logic            squash;
  logic [PTR_W:0]  fl_count;

  always #5 clock = ~clock;

  free_list u_dut (
    .clock           (clock),
    .reset           (reset),
    .i_dis_new_pr_en (dis_en),
    .o_free_pr_valid (free_pr_valid),
    .o_free_pr       (free_pr),
    .i_retire_en     (retire_en),
    .i_retire_told   (retire_told),
    .i_squash        (squash),
    .o_fl_count      (fl_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: free tags in allocation order, and allocated-but-not-retired tags oldest first.
  int unsigned free_q[$];
  int unsigned infl_q[$];
  bit          model_ok = 1'b0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic int fp(input int way);
    return int'(free_pr[way*PR +: PR]);
  endfunction

  task automatic idle();
    dis_en = 3'b000; retire_en = 3'b000; retire_told = '0; squash = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_retire(input logic [2:0] en, input int t2, input int t1, input int t0);
    retire_en   = en;
    retire_told = {PR_TAG'(t2), PR_TAG'(t1), PR_TAG'(t0)};
  endtask

  int unsigned m_n;
  int unsigned m_tag;
  always @(posedge clock) begin
    if (reset) begin
      free_q.delete();
      infl_q.delete();
      for (int unsigned i = 0; i < FL_SIZE; i++) free_q.push_back(AR_NUM + i);
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (!squash) begin
        m_n = $countones(dis_en);
        if (m_n > free_q.size()) m_n = free_q.size();
        repeat (m_n) infl_q.push_back(free_q.pop_front());
      end
      for (int w = 2; w >= 0; w--) begin
        if (retire_en[w]) begin
          if (infl_q.size() > 0) void'(infl_q.pop_front());
          m_tag = int'(retire_told[w*PR +: PR]);
          free_q.push_back(m_tag);
        end
      end
      if (squash) begin
        free_q = {infl_q, free_q};
        infl_q.delete();
      end
    end
  end

  int unsigned c_sz;
  int unsigned c_i1;
  int unsigned c_i0;
  int          c_valid;
  always @(negedge clock) begin
    if (model_ok) begin
      c_sz    = free_q.size();
      c_valid = (c_sz >= 3) ? 7 : (c_sz == 2) ? 6 : (c_sz == 1) ? 4 : 0;
      chk("valid", int'(free_pr_valid), c_valid);
      chk("count", int'(fl_count), int'(c_sz));
      if (c_sz > 0) chk("free_pr2", fp(2), int'(free_q[0]));
      c_i1 = {31'd0, dis_en[2]};
      c_i0 = c_i1 + {31'd0, dis_en[1]};
      if (dis_en[1] && c_i1 < c_sz) chk("free_pr1", fp(1), int'(free_q[c_i1]));
      if (dis_en[0] && c_i0 < c_sz) chk("free_pr0", fp(0), int'(free_q[c_i0]));
    end
  end

  logic [2:0]  r_e;
  logic [2:0]  r_r;
  int unsigned r_sz;
  int unsigned r_inf;
  int unsigned r_phase;

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state and a full 3-way allocation.
    #1;
    chk("rst_count", int'(fl_count), 32);
    chk("rst_valid", int'(free_pr_valid), 7);
    dis_en = 3'b111;
    #1;
    chk("t1_fp2", fp(2), 32);
    chk("t1_fp1", fp(1), 33);
    chk("t1_fp0", fp(0), 34);
    tick();
    idle();
    #1;
    chk("t1_next_fp2", fp(2), 35);
    chk("t1_count", int'(fl_count), 29);

    // Sparse enables compact past the idle way.
    do_reset();
    dis_en = 3'b101;
    #1;
    chk("t2_fp2", fp(2), 32);
    chk("t2_fp0", fp(0), 33);
    tick();
    idle();
    #1;
    chk("t2_next_fp2", fp(2), 34);
    chk("t2_count", int'(fl_count), 30);

    // Drain to empty, enables ignored, then one freed tag reappears.
    do_reset();
    dis_en = 3'b111;
    repeat (10) tick();
    dis_en = 3'b110;
    tick();
    idle();
    #1;
    chk("t3_empty_count", int'(fl_count), 0);
    chk("t3_empty_valid", int'(free_pr_valid), 0);
    dis_en = 3'b111;
    tick();
    idle();
    set_retire(3'b100, 5, 0, 0);
    tick();
    idle();
    #1;
    chk("t3_valid", int'(free_pr_valid), 4);
    chk("t3_fp2", fp(2), 5);
    chk("t3_count", int'(fl_count), 1);

    // Retire two, then squash back to the architectural head.
    do_reset();
    dis_en = 3'b111;
    repeat (2) tick();
    idle();
    set_retire(3'b011, 0, 7, 9);
    tick();
    idle();
    #1;
    chk("t4_count", int'(fl_count), 28);
    chk("t4_fp2", fp(2), 38);
    squash = 1'b1;
    tick();
    idle();
    #1;
    chk("t5_count", int'(fl_count), 32);
    chk("t5_fp2", fp(2), 34);

    // Pointer wrap, then reset overriding a busy squash cycle.
    do_reset();
    dis_en = 3'b111;
    repeat (10) tick();
    idle();
    set_retire(3'b111, 1, 2, 3);
    tick();
    idle();
    dis_en = 3'b111;
    #1;
    chk("t6_fp2", fp(2), 62);
    chk("t6_fp1", fp(1), 63);
    chk("t6_fp0", fp(0), 1);
    tick();
    idle();
    #1;
    chk("t6_next_fp2", fp(2), 2);
    chk("t6_count", int'(fl_count), 2);
    reset = 1'b1;
    squash = 1'b1;
    dis_en = 3'b111;
    set_retire(3'b111, 10, 11, 12);
    tick();
    reset = 1'b0;
    idle();
    dis_en = 3'b111;
    #1;
    chk("t6_rst_count", int'(fl_count), 32);
    chk("t6_rst_valid", int'(free_pr_valid), 7);
    chk("t6_rst_fp2", fp(2), 32);
    chk("t6_rst_fp1", fp(1), 33);
    chk("t6_rst_fp0", fp(0), 34);
    tick();
    idle();

    // Random traffic with phases that alternately drain and refill the list.
    for (int c = 0; c < 4000; c++) begin
      r_sz    = free_q.size();
      r_inf   = infl_q.size();
      r_phase = (c / 200) % 2;
      r_e = 3'($urandom);
      if (r_sz > 0) begin
        while ($countones(r_e) > r_sz) r_e = r_e & (r_e - 3'd1);
      end
      r_r = 3'($urandom);
      if (r_phase == 0 && $urandom_range(0, 3) != 0) r_r = 3'b000;
      if (r_phase == 1 && $urandom_range(0, 1) == 0) r_e = 3'b000;
      while ($countones(r_r) > r_inf) r_r = r_r & (r_r - 3'd1);
      dis_en = r_e;
      set_retire(r_r, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
      squash = ($urandom_range(0, 79) == 0);
      reset  = ($urandom_range(0, 999) == 0);
      tick();
    end
    idle();
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
